// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and the datapath: instruction/halt inputs,
// datapath strobes, register-select lines, ALU select and run status.
interface control_sequencer_if;
  logic [31:0] IR;
  logic        stop;
  logic        PCout, PCin, MARin, IncPC, read, MDRin, MDRout, IRin, Yin;
  logic        Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin;
  logic        Gra, Grb, Grc, Rin, Rout;
  logic [4:0]  ALU;
  logic        run;

  modport master (
    input  IR, stop,
    output PCout, PCin, MARin, IncPC, read, MDRin, MDRout, IRin, Yin,
           Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin,
           Gra, Grb, Grc, Rin, Rout, ALU, run
  );

  modport slave (
    output IR, stop,
    input  PCout, PCin, MARin, IncPC, read, MDRin, MDRout, IRin, Yin,
           Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin,
           Gra, Grb, Grc, Rin, Rout, ALU, run
  );
endinterface

// File: rtl/control_sequencer.sv
// Moore control sequencer for a register/ALU datapath (fetch T0-T2, execute T3-T6).
// Define CTRL_MULDIV_EN to enable the MUL/DIV sequence; otherwise those opcodes act as NOP.
//
// state   | meaning
// RESET   | held by clear, all outputs 0
// T0      | PC to MAR, increment PC; stop sampled here
// T1      | memory read into MDR, PC updated
// T2      | MDR to IR
// T3      | first execute step (operand to Y)
// T4      | ALU operation
// T5      | result write-back (LO for MUL/DIV)
// T6      | HI write-back, MUL/DIV only
// HALT    | absorbing, left only via clear
module control_sequencer (
  input logic                  clock,
  input logic                  clear,
  control_sequencer_if.master  bus
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  typedef enum logic [1:0] {K_ALU3, K_MULDIV, K_NOP, K_HALT} kind_t;

  typedef struct packed {
    logic PCout, PCin, MARin, IncPC, read, MDRin, MDRout, IRin, Yin;
    logic Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin;
    logic Gra, Grb, Grc, Rin, Rout;
    logic [4:0] ALU;
  } strobes_t;

  state_t   state;
  strobes_t strb;
  strobes_t t3;
  strobes_t outs;
  kind_t    kind;
  logic [4:0] alu_code;
  logic [4:0] opcode;

  assign opcode = bus.IR[31:27];

  always_comb begin
    kind     = K_NOP;
    alu_code = 5'b00000;
    case (opcode)
      5'b00011: begin kind = K_ALU3;   alu_code = 5'b00000; end
      5'b00100: begin kind = K_ALU3;   alu_code = 5'b00001; end
      5'b00101: begin kind = K_ALU3;   alu_code = 5'b00100; end
      5'b00110: begin kind = K_ALU3;   alu_code = 5'b00101; end
`ifdef CTRL_MULDIV_EN
      5'b01111: begin kind = K_MULDIV; alu_code = 5'b00010; end
      5'b10000: begin kind = K_MULDIV; alu_code = 5'b00011; end
`endif
      5'b11011: kind = K_HALT;
      default:  kind = K_NOP;
    endcase
  end

  function automatic strobes_t t0_strobes();
    strobes_t s;
    s        = '0;
    s.PCout  = 1'b1;
    s.MARin  = 1'b1;
    s.IncPC  = 1'b1;
    s.Zlowin = 1'b1;
    return s;
  endfunction

  // Strobes are registered alongside the state: each branch loads those of the state being entered.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state <= S_RESET;
      strb  <= '0;
    end else begin
      strb <= '0;
      case (state)
        S_RESET: begin state <= S_T0; strb <= t0_strobes(); end
        S_T0: begin
          if (bus.stop) begin
            state <= S_HALT;
          end else begin
            state        <= S_T1;
            strb.Zlowout <= 1'b1;
            strb.PCin    <= 1'b1;
            strb.read    <= 1'b1;
            strb.MDRin   <= 1'b1;
          end
        end
        S_T1: begin state <= S_T2; strb.MDRout <= 1'b1; strb.IRin <= 1'b1; end
        S_T2: state <= S_T3;
        S_T3: begin
          case (kind)
            K_ALU3: begin
              state <= S_T4; strb.Grc <= 1'b1; strb.Rout <= 1'b1;
              strb.Zlowin <= 1'b1; strb.ALU <= alu_code;
            end
            K_MULDIV: begin
              state <= S_T4; strb.Grb <= 1'b1; strb.Rout <= 1'b1;
              strb.Zlowin <= 1'b1; strb.Zhighin <= 1'b1; strb.ALU <= alu_code;
            end
            K_HALT:  state <= S_HALT;
            default: begin state <= S_T0; strb <= t0_strobes(); end
          endcase
        end
        S_T4: begin
          state        <= S_T5;
          strb.Zlowout <= 1'b1;
          if (kind == K_MULDIV) begin
            strb.LOin <= 1'b1;
          end else begin
            strb.Gra <= 1'b1;
            strb.Rin <= 1'b1;
          end
        end
        S_T5: begin
          if (kind == K_MULDIV) begin
            state <= S_T6; strb.Zhighout <= 1'b1; strb.HIin <= 1'b1;
          end else begin
            state <= S_T0; strb <= t0_strobes();
          end
        end
        S_T6:    begin state <= S_T0; strb <= t0_strobes(); end
        S_HALT:  state <= S_HALT;
        default: state <= S_RESET;
      endcase
    end
  end

  // IR is only loaded at the T2->T3 edge, so T3 strobes are decoded from the live IR.
  always_comb begin
    t3 = '0;
    if (state == S_T3) begin
      if (kind == K_ALU3) begin
        t3.Grb = 1'b1; t3.Rout = 1'b1; t3.Yin = 1'b1;
      end else if (kind == K_MULDIV) begin
        t3.Gra = 1'b1; t3.Rout = 1'b1; t3.Yin = 1'b1;
      end
    end
    outs = strobes_t'(strb | t3);
  end

  assign bus.PCout   = outs.PCout;
  assign bus.PCin    = outs.PCin;
  assign bus.MARin   = outs.MARin;
  assign bus.IncPC   = outs.IncPC;
  assign bus.read    = outs.read;
  assign bus.MDRin   = outs.MDRin;
  assign bus.MDRout  = outs.MDRout;
  assign bus.IRin    = outs.IRin;
  assign bus.Yin     = outs.Yin;
  assign bus.Zlowin  = outs.Zlowin;
  assign bus.Zlowout = outs.Zlowout;
  assign bus.Gra     = outs.Gra;
  assign bus.Grb     = outs.Grb;
  assign bus.Grc     = outs.Grc;
  assign bus.Rin     = outs.Rin;
  assign bus.Rout    = outs.Rout;
  assign bus.ALU     = outs.ALU;
  assign bus.run     = (state != S_RESET) && (state != S_HALT);

`ifdef CTRL_MULDIV_EN
  assign bus.Zhighin  = outs.Zhighin;
  assign bus.Zhighout = outs.Zhighout;
  assign bus.LOin     = outs.LOin;
  assign bus.HIin     = outs.HIin;
  logic unused_bits;
  assign unused_bits = ^bus.IR[26:0];
`else
  assign bus.Zhighin  = 1'b0;
  assign bus.Zhighout = 1'b0;
  assign bus.LOin     = 1'b0;
  assign bus.HIin     = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{bus.IR[26:0], outs.Zhighin, outs.Zhighout, outs.LOin, outs.HIin};
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected per-cycle output vectors are queued
// with each stimulus step and compared one per clock, sampled 1 ns after the rising edge.
module tb_control_sequencer;

  logic clock = 1'b0;
  logic clear = 1'b0;
  control_sequencer_if bus ();

  control_sequencer dut (.clock(clock), .clear(clear), .bus(bus));

  always #5 clock = ~clock;

  // Bit layout of the observed vector
  localparam logic [25:0] B_PCOUT    = 26'd1 << 25;
  localparam logic [25:0] B_PCIN     = 26'd1 << 24;
  localparam logic [25:0] B_MARIN    = 26'd1 << 23;
  localparam logic [25:0] B_INCPC    = 26'd1 << 22;
  localparam logic [25:0] B_READ     = 26'd1 << 21;
  localparam logic [25:0] B_MDRIN    = 26'd1 << 20;
  localparam logic [25:0] B_MDROUT   = 26'd1 << 19;
  localparam logic [25:0] B_IRIN     = 26'd1 << 18;
  localparam logic [25:0] B_YIN      = 26'd1 << 17;
  localparam logic [25:0] B_ZLOWIN   = 26'd1 << 16;
  localparam logic [25:0] B_ZHIGHIN  = 26'd1 << 15;
  localparam logic [25:0] B_ZLOWOUT  = 26'd1 << 14;
  localparam logic [25:0] B_ZHIGHOUT = 26'd1 << 13;
  localparam logic [25:0] B_LOIN     = 26'd1 << 12;
  localparam logic [25:0] B_HIIN     = 26'd1 << 11;
  localparam logic [25:0] B_GRA      = 26'd1 << 10;
  localparam logic [25:0] B_GRB      = 26'd1 << 9;
  localparam logic [25:0] B_GRC      = 26'd1 << 8;
  localparam logic [25:0] B_RIN      = 26'd1 << 7;
  localparam logic [25:0] B_ROUT     = 26'd1 << 6;
  localparam logic [25:0] B_RUN      = 26'd1;

  localparam logic [25:0] E_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN | B_RUN;
  localparam logic [25:0] E_T1 = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN | B_RUN;
  localparam logic [25:0] E_T2 = B_MDROUT | B_IRIN | B_RUN;

  localparam int K_ALU3 = 0, K_MULDIV = 1, K_NOP = 2, K_HALT = 3;

  logic [25:0] obs;
  assign obs = {bus.PCout, bus.PCin, bus.MARin, bus.IncPC, bus.read, bus.MDRin,
                bus.MDRout, bus.IRin, bus.Yin, bus.Zlowin, bus.Zhighin, bus.Zlowout,
                bus.Zhighout, bus.LOin, bus.HIin, bus.Gra, bus.Grb, bus.Grc, bus.Rin,
                bus.Rout, bus.ALU, bus.run};

  typedef struct {
    string       tag;
    logic [25:0] val;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic push_exp(input string tag, input logic [25:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  function automatic logic [25:0] alu_f(input logic [4:0] a);
    return {20'b0, a, 1'b0};
  endfunction

  // Cycles T1 onward of one instruction, up to but excluding the next T0/HALT.
  task automatic push_body(input string nm, input int kind, input logic [4:0] alu);
    push_exp({nm, "_T1"}, E_T1);
    push_exp({nm, "_T2"}, E_T2);
    case (kind)
      K_ALU3: begin
        push_exp({nm, "_T3"}, B_GRB | B_ROUT | B_YIN | B_RUN);
        push_exp({nm, "_T4"}, B_GRC | B_ROUT | B_ZLOWIN | alu_f(alu) | B_RUN);
        push_exp({nm, "_T5"}, B_ZLOWOUT | B_GRA | B_RIN | B_RUN);
      end
      K_MULDIV: begin
        push_exp({nm, "_T3"}, B_GRA | B_ROUT | B_YIN | B_RUN);
        push_exp({nm, "_T4"}, B_GRB | B_ROUT | B_ZLOWIN | B_ZHIGHIN | alu_f(alu) | B_RUN);
        push_exp({nm, "_T5"}, B_ZLOWOUT | B_LOIN | B_RUN);
        push_exp({nm, "_T6"}, B_ZHIGHOUT | B_HIIN | B_RUN);
      end
      default: push_exp({nm, "_T3"}, B_RUN);
    endcase
  endtask

  task automatic step_n(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_underrun: queue empty, expected an entry");
      end else begin
        e = sb.pop_front();
        chk_val(e.tag, {6'b0, obs}, {6'b0, e.val});
      end
    end
  endtask

  task automatic drain();
    step_n(sb.size());
  endtask

  // Runs one instruction starting from T0 and ending in the following T0.
  task automatic run_instr(input string nm, input logic [31:0] ir, input int kind,
                           input logic [4:0] alu);
    bus.IR = ir;
    push_body(nm, kind, alu);
    push_exp({nm, "_nextT0"}, E_T0);
    drain();
  endtask

  task automatic do_reset();
    clear = 1'b0;
    push_exp("rst", 26'd0);
    step_n(1);
    clear = 1'b1;
    push_exp("rst_T0", E_T0);
    step_n(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.IR   = 32'h28918000;
    bus.stop = 1'b0;
    clear    = 1'b0;

    push_exp("rst_c1", 26'd0);
    push_exp("rst_c2", 26'd0);
    step_n(2);
    clear = 1'b1;
    push_exp("first_T0", E_T0);
    step_n(1);

    run_instr("and", 32'h28918000, K_ALU3, 5'b00100);
    run_instr("add", 32'h18000000, K_ALU3, 5'b00000);
    run_instr("sub", 32'h20000000, K_ALU3, 5'b00001);
    run_instr("or",  32'h30000000, K_ALU3, 5'b00101);
`ifdef CTRL_MULDIV_EN
    run_instr("mul", 32'h78918000, K_MULDIV, 5'b00010);
    run_instr("div", 32'h80000000, K_MULDIV, 5'b00011);
`else
    run_instr("mul", 32'h78918000, K_NOP, 5'b00000);
    run_instr("div", 32'h80000000, K_NOP, 5'b00000);
`endif
    run_instr("nop", 32'hD0000000, K_NOP, 5'b00000);
    run_instr("ill", 32'hF8000000, K_NOP, 5'b00000);

    // stop raised in T4 and held: the ADD completes, next T0 runs, then HALT.
    bus.IR = 32'h18000000;
    push_body("stp", K_ALU3, 5'b00000);
    step_n(4);
    bus.stop = 1'b1;
    drain();
    push_exp("stp_T0", E_T0);
    for (int i = 0; i < 12; i++) push_exp("stp_halt", 26'd0);
    drain();
    bus.stop = 1'b0;
    do_reset();

    // clear in T4 abandons the instruction.
    bus.IR = 32'h18000000;
    push_body("abort", K_ALU3, 5'b00000);
    step_n(4);
    sb.delete();
    clear = 1'b0;
    push_exp("abort_rst", 26'd0);
    step_n(1);
    clear = 1'b1;
    push_exp("abort_T0", E_T0);
    step_n(1);
    run_instr("post_abort", 32'h30000000, K_ALU3, 5'b00101);

    // HALT opcode: absorbing until clear.
    bus.IR = 32'hD8000000;
    push_body("hlt", K_HALT, 5'b00000);
    for (int i = 0; i < 12; i++) push_exp("hlt_idle", 26'd0);
    drain();
    do_reset();
    run_instr("post_halt", 32'h28918000, K_ALU3, 5'b00100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
